fifo_top: RTL and testbench
===========================

FIFO_TOP -- requirements
Module: fifo_top

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of entries (power of two).
REQ-003 The block SHALL have parameter AF_LVL, default 14, occupancy at or above which f_almost_full asserts.
REQ-004 The block SHALL have parameter AE_LVL, default 2, occupancy at or below which f_almost_empty asserts.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 The block SHALL have port data_in, input, DATA_W, write data.
REQ-008 The block SHALL have port enable_wr, input, 1, write request.
REQ-009 The block SHALL have port enable_rd, input, 1, read request.
REQ-010 The block SHALL have port data_out, output, DATA_W, registered read data.
REQ-011 The block SHALL have flag outputs f_empty, f_full, f_almost_full, f_almost_empty, f_half and f_healthy, each an output of width 1.

Function
REQ-012 The block SHALL keep a write pointer, a read pointer (each log2(DEPTH) bits, wrapping DEPTH-1 -> 0) and an occupancy count (log2(DEPTH)+1 bits, range 0..DEPTH).
REQ-013 A write SHALL occur on a clock edge when enable_wr=1 and count<DEPTH: store data_in at the write pointer and increment the write pointer.
REQ-014 A read SHALL occur on a clock edge when enable_rd=1 and count>0: load data_out from the read pointer and increment the read pointer; data appears one cycle after the request.
REQ-015 When no read occurs, data_out SHALL hold its previous value.
REQ-016 A write when full and a read when empty SHALL be ignored, with no pointer, count or data_out change and no error output.
REQ-017 A simultaneous valid read and write SHALL both execute and leave count unchanged.
REQ-018 When empty, a simultaneous request SHALL perform only the write (count 0->1, data_out unchanged).
REQ-019 When full, a simultaneous request SHALL perform only the read (count DEPTH->DEPTH-1).
REQ-020 All flags SHALL be combinational decodes of the registered count, reflecting an access in the cycle after its edge.
REQ-021 The flags SHALL decode as: f_empty = (count==0); f_full = (count==DEPTH); f_almost_full = (count>=AF_LVL); f_almost_empty = (count<=AE_LVL); f_half = (count>=DEPTH/2).
REQ-022 f_healthy SHALL equal (count>AE_LVL) and (count<AF_LVL).
REQ-023 Data SHALL be read out in write order (first in, first out) across pointer wrap-around.

Reset
REQ-024 When reset=1 at a clock edge, the block SHALL clear pointers and count to 0 and set data_out to 0, overriding enable_wr and enable_rd in that cycle.
REQ-025 After reset the outputs SHALL be f_empty=1, f_almost_empty=1, f_full=0, f_almost_full=0, f_half=0 and f_healthy=0.
REQ-026 Reset SHALL NOT clear the memory array contents, and reset asserted mid-operation SHALL discard all stored entries.

Structure
REQ-027 DATA_W, DEPTH, AF_LVL, AE_LVL and the derived pointer width SHALL be defined in a shared package fifo_pkg.
REQ-028 Storage SHALL be a sub-module fifo_mem, a DEPTH x DATA_W register array with one synchronous write port and one registered read port.
REQ-029 Pointer, count and flag logic SHALL reside in fifo_top.

Verification
REQ-030 Verification SHALL hold reset for 2 cycles, then check data_out=0, f_empty=1, f_almost_empty=1 and every other flag 0.
REQ-031 Verification SHALL write 0x01..0x10 (16 words) and check: f_almost_empty drops at count 3; f_healthy is 1 for counts 3..13; f_half rises at count 8; f_almost_full rises at count 14; f_full rises at count 16.
REQ-032 Verification SHALL, with the FIFO full, write 0xAA, then read all 16 words and check data_out = 0x01..0x10 in order, 0xAA never appears, and f_empty=1 at the end.
REQ-033 Verification SHALL, with the FIFO empty, issue a read and check data_out and count unchanged; it SHALL then issue a simultaneous read and write of 0x55 and check count=1, with the next read returning 0x55.
REQ-034 Verification SHALL, at steady count 5, run 40 cycles of simultaneous read and write with incrementing data and check count stays 5 and the output sequence stays in order across pointer wrap.
REQ-035 Verification SHALL write 10 words, assert reset for 1 cycle with enable_wr=1, and check count=0, f_empty=1 and data_out=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing, flag bundle and occupancy decode for the synchronous FIFO.
// The top-level parameters default to the values defined here.
package fifo_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF_LVL = 14;
  localparam int AE_LVL = 2;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // The two valid-access bits concatenated as {write, read}.
  typedef enum logic [1:0] {
    ACC_IDLE = 2'b00,
    ACC_RD   = 2'b01,
    ACC_WR   = 2'b10,
    ACC_RW   = 2'b11
  } access_e;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
    logic half;
    logic healthy;
  } flags_t;

  function automatic flags_t decode_flags(input int unsigned count,
                                          input int unsigned depth,
                                          input int unsigned af_lvl,
                                          input int unsigned ae_lvl);
    flags_t f;
    f.empty        = (count == 0);
    f.full         = (count == depth);
    f.almost_full  = (count >= af_lvl);
    f.almost_empty = (count <= ae_lvl);
    f.half         = (count >= depth / 2);
    f.healthy      = (count > ae_lvl) && (count < af_lvl);
    return f;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// registered read port whose output register is cleared by reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int DEPTH  = fifo_pkg::DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the storage array deliberately has no reset; stale words are
  // unreachable once the pointers are cleared, and leaving it out lets
  // the array map onto plain flops or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so
  // every register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_top.sv
// Single-clock FIFO: pointer, occupancy and flag logic around fifo_mem.
// Overflowing writes and underflowing reads are silently dropped.
module fifo_top
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int DEPTH  = fifo_pkg::DEPTH,
  parameter int AF_LVL = fifo_pkg::AF_LVL,
  parameter int AE_LVL = fifo_pkg::AE_LVL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enable_wr,
  input  logic              enable_rd,
  output logic [DATA_W-1:0] data_out,
  output logic              f_empty,
  output logic              f_full,
  output logic              f_almost_full,
  output logic              f_almost_empty,
  output logic              f_half,
  output logic              f_healthy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_wr, do_rd;
  access_e          access;
  flags_t           flags;

  // Qualify requests against the registered occupancy; reset wins.
  assign do_wr  = enable_wr && (count_q != CNT_W'(DEPTH)) && !reset;
  assign do_rd  = enable_rd && (count_q != '0) && !reset;
  assign access = access_e'({do_wr, do_rd});

  // NOTE: every variable driven here gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (access)
      ACC_WR: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      ACC_RD: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
      ACC_RW: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (do_wr),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (do_rd),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

  // Flags are pure decodes of the registered count.
  assign flags = decode_flags(32'(count_q), DEPTH, AF_LVL, AE_LVL);

  assign f_empty        = flags.empty;
  assign f_full         = flags.full;
  assign f_almost_full  = flags.almost_full;
  assign f_almost_empty = flags.almost_empty;
  assign f_half         = flags.half;
  assign f_healthy      = flags.healthy;

endmodule

// File: tb/tb_fifo_top.sv
// Randomised and directed checks of fifo_top against a queue-based model.
module tb_fifo_top;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          enable_wr = 1'b0;
  logic          enable_rd = 1'b0;
  logic [DW-1:0] data_out;
  logic          f_empty, f_full, f_almost_full, f_almost_empty, f_half, f_healthy;

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_dout = '0;

  fifo_top #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .enable_wr      (enable_wr),
    .enable_rd      (enable_rd),
    .data_out       (data_out),
    .f_empty        (f_empty),
    .f_full         (f_full),
    .f_almost_full  (f_almost_full),
    .f_almost_empty (f_almost_empty),
    .f_half         (f_half),
    .f_healthy      (f_healthy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // {empty, full, almost_full, almost_empty, half, healthy}
  function automatic logic [5:0] exp_flags(input int c);
    return {c == 0, c == DEPTH, c >= AF, c <= AE, c >= DEPTH / 2, (c > AE) && (c < AF)};
  endfunction

  function automatic logic [5:0] obs_flags();
    return {f_empty, f_full, f_almost_full, f_almost_empty, f_half, f_healthy};
  endfunction

  // Drive one cycle, advance the model on the edge, sample 1 ns later.
  task automatic step(input logic wr, input logic rd, input logic rst, input logic [DW-1:0] d);
    bit take_wr, take_rd;
    enable_wr = wr;
    enable_rd = rd;
    reset     = rst;
    data_in   = d;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      exp_dout = '0;
    end else begin
      take_rd = rd && (model_q.size() > 0);
      take_wr = wr && (model_q.size() < DEPTH);
      if (take_rd) exp_dout = model_q.pop_front();
      if (take_wr) model_q.push_back(d);
    end
    #1;
    enable_wr = 1'b0;
    enable_rd = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 8'h3C);
    step(1'b1, 1'b0, 1'b1, 8'h5A);
    n_total++;
    if (data_out !== 8'h00) $display("FAIL reset_dout: got %h expected 00", data_out);
    else n_pass++;
    n_total++;
    if (obs_flags() !== 6'b100100) $display("FAIL reset_flags: got %b expected 100100", obs_flags());
    else n_pass++;
  endtask

  task automatic test_fill_flags();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i));
      n_total++;
      if (obs_flags() !== exp_flags(i)) $display("FAIL fill_flags[%0d]: got %b expected %b", i, obs_flags(), exp_flags(i));
      else n_pass++;
      n_total++;
      if (int'(dut.count_q) !== i) $display("FAIL fill_count[%0d]: got %0d expected %0d", i, dut.count_q, i);
      else n_pass++;
    end
  endtask

  task automatic test_overflow_drain();
    step(1'b1, 1'b0, 1'b0, 8'hAA);
    n_total++;
    if (int'(dut.count_q) !== DEPTH || f_full !== 1'b1)
      $display("FAIL overflow_count: got %0d full=%b expected %0d full=1", dut.count_q, f_full, DEPTH);
    else n_pass++;
    n_total++;
    if (data_out !== exp_dout) $display("FAIL overflow_dout: got %h expected %h", data_out, exp_dout);
    else n_pass++;
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      n_total++;
      if (data_out !== 8'(i)) $display("FAIL drain_data[%0d]: got %h expected %h", i, data_out, 8'(i));
      else n_pass++;
      n_total++;
      if (obs_flags() !== exp_flags(DEPTH - i)) $display("FAIL drain_flags[%0d]: got %b expected %b", i, obs_flags(), exp_flags(DEPTH - i));
      else n_pass++;
    end
    n_total++;
    if (f_empty !== 1'b1) $display("FAIL drain_empty: got %b expected 1", f_empty);
    else n_pass++;
  endtask

  task automatic test_empty_ops();
    logic [DW-1:0] held;
    held = exp_dout;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    n_total++;
    if (data_out !== held || int'(dut.count_q) !== 0)
      $display("FAIL empty_read: got dout=%h count=%0d expected dout=%h count=0", data_out, dut.count_q, held);
    else n_pass++;
    step(1'b1, 1'b1, 1'b0, 8'h55);
    n_total++;
    if (int'(dut.count_q) !== 1 || data_out !== held)
      $display("FAIL empty_rw: got count=%0d dout=%h expected count=1 dout=%h", dut.count_q, data_out, held);
    else n_pass++;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    n_total++;
    if (data_out !== 8'h55) $display("FAIL empty_rw_read: got %h expected 55", data_out);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    d = 8'hC0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, d);
      d++;
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0, d);
      d++;
      n_total++;
      if (int'(dut.count_q) !== 5 || data_out !== 8'(8'hC0 + i))
        $display("FAIL b2b[%0d]: got count=%0d dout=%h expected count=5 dout=%h", i, dut.count_q, data_out, 8'(8'hC0 + i));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h70 + i));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'hEE);
    n_total++;
    if (int'(dut.count_q) !== 0 || f_empty !== 1'b1 || data_out !== 8'h00)
      $display("FAIL reset_mid: got count=%0d empty=%b dout=%h expected 0/1/00", dut.count_q, f_empty, data_out);
    else n_pass++;
  endtask

  task automatic test_random();
    int wr_pct;
    for (int i = 0; i < 600; i++) begin
      wr_pct = (i < 200) ? 75 : (i < 400) ? 25 : 50;
      step($urandom_range(99) < wr_pct, $urandom_range(99) < 50,
           $urandom_range(199) == 0, 8'($urandom));
      n_total++;
      if (data_out !== exp_dout || obs_flags() !== exp_flags(model_q.size()) ||
          int'(dut.count_q) !== model_q.size())
        $display("FAIL random[%0d]: got dout=%h flags=%b count=%0d expected dout=%h flags=%b count=%0d",
                 i, data_out, obs_flags(), dut.count_q, exp_dout, exp_flags(model_q.size()), model_q.size());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fill_flags();
    test_overflow_drain();
    test_empty_ops();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
